axis_32to64: RTL
================

// Module: axis_32to64
// PURPOSE
//   AXI4-Stream width up-converter: packs pairs of 32-bit slave beats into one
//   64-bit master beat. First beat goes to [31:0], second beat to [63:32].
//   Return path of the 64->32 down-converter: rebuilds 64-bit words for the
//   DMA/host side and re-attaches the packet's SRCDEST word as TUSER.
//   Odd-length packets are closed with a half-filled, TKEEP-marked last beat.
// PARAMETERS
//   PAD_WORD  32'h00000000  value driven on [63:32] of a half-filled last beat
//   USER_W    32            width of SRCDEST / M_AXIS_TUSER
// PORTS
//   AXIS_ACLK      in   1       single clock, all logic rising-edge
//   AXIS_ARESETN   in   1       asynchronous active-low reset
//   S_AXIS_TDATA   in   32      slave data
//   S_AXIS_TVALID  in   1       slave valid
//   S_AXIS_TLAST   in   1       slave end-of-packet
//   S_AXIS_TREADY  out  1       slave ready
//   SRCDEST        in   USER_W  packet routing word, sampled on first beat of packet
//   M_AXIS_TDATA   out  64      master data
//   M_AXIS_TKEEP   out  8       8'hFF full beat, 8'h0F low half only
//   M_AXIS_TLAST   out  1       master end-of-packet
//   M_AXIS_TUSER   out  USER_W  SRCDEST captured at start of packet
//   M_AXIS_TVALID  out  1       master valid
//   M_AXIS_TREADY  in   1       master ready
// BEHAVIOUR
//   - s_xfr = S_AXIS_TVALID & S_AXIS_TREADY; m_xfr = M_AXIS_TVALID & M_AXIS_TREADY.
//   - Reset (async assert, sync release): all registers 0; TVALID=0, TDATA=0, TKEEP=0,
//     TLAST=0, TUSER=0, low-half empty, sop=1. Reset mid-packet discards partial data.
//   - Registered output stage: M_AXIS_* come from flops only, no comb path from S to M.
//   - S_AXIS_TREADY = ~out_valid | M_AXIS_TREADY (no comb path from S_AXIS_TVALID).
//   - States (lo_valid, out_valid):
//     LO_EMPTY: s_xfr & ~TLAST -> lo_reg<=TDATA, lo_valid<=1 (-> LO_HELD).
//               s_xfr & TLAST  -> out<= {PAD_WORD,TDATA}, TKEEP 8'h0F, TLAST 1, out_valid<=1.
//     LO_HELD:  s_xfr -> out<={TDATA,lo_reg}, TKEEP 8'hFF, TLAST<=S_AXIS_TLAST,
//               out_valid<=1, lo_valid<=0 (-> LO_EMPTY).
//   - out_valid: set on load, cleared on m_xfr without simultaneous load; load and
//     m_xfr in the same cycle -> new beat replaces old, out_valid stays 1.
//   - Output held stable while TVALID=1 & TREADY=0 (AXIS rule); no beat dropped or duplicated.
//   - sop flag: set by reset and by s_xfr with TLAST; cleared by s_xfr without TLAST.
//     On s_xfr with sop=1, user_reg<=SRCDEST; M_AXIS_TUSER loaded from user_reg
//     (or directly from SRCDEST for a 1-beat packet) with each output beat.
//   - Latency: output valid 1 cycle after the second (or last) accepted slave beat.
//   - Throughput: one slave beat per cycle while master ready; 1 master beat / 2 cycles.
//   - TLAST on first (low) beat of a pair never waits for a second beat.
// TESTING
//   1. Reset, M ready=1; send 4 beats 11111111,22222222,33333333,44444444(LAST) ->
//      64'h22222222_11111111 KEEP FF LAST0, then 64'h44444444_33333333 KEEP FF LAST1.
//   2. 3-beat packet A,B,C(LAST) -> {B,A} KEEP FF LAST0, {PAD_WORD,C} KEEP 0F LAST1.
//   3. Single-beat packet DEADBEEF(LAST), SRCDEST=0x5 -> {00000000,DEADBEEF} KEEP 0F,
//      LAST1, TUSER=0x5; next packet SRCDEST=0x9 on its first beat -> TUSER=0x9.
//   4. M_AXIS_TREADY=0 for 10 cycles with full output: TVALID/TDATA stable, S_AXIS_TREADY=0,
//      no loss; release -> stream resumes in order with correct KEEP/LAST.
//   5. Random TVALID/TREADY toggling, 1000 packets of length 1..33 -> scoreboard match,
//      including TKEEP on odd lengths and TUSER per packet.
//   6. Assert AXIS_ARESETN low mid-pair (LO_HELD, out_valid=1) -> outputs 0 immediately;
//      after release a fresh 2-beat packet emits exactly one correct 64-bit beat.

Source files
------------

// File: rtl/axis_32to64_if.sv
// AXI4-Stream bundle shared by both sides of the 32->64 packer.
// The width of tkeep follows the width of tdata.
interface axis_32to64_if #(
  parameter int DW = 32,
  parameter int UW = 32
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0]   tuser;
  logic            tvalid;
  logic            tlast;
  logic            tready;

  modport master (
    output tdata, tkeep, tuser,
    output tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tuser,
    input  tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/axis_32to64.sv
// AXI4-Stream 32->64 up-converter with a registered output stage.
// Odd packets close with a low-half beat; TUSER is the packet's SRCDEST.
module axis_32to64 #(
  parameter logic [31:0] PAD_WORD = 32'h0000_0000,
  parameter int          USER_W   = 32
) (
  input  logic          AXIS_ACLK,
  input  logic          AXIS_ARESETN,
  axis_32to64_if.slave  s_axis,
  axis_32to64_if.master m_axis
);

  typedef enum logic {
    LO_EMPTY,
    LO_HELD
  } lo_state_e;

  lo_state_e state_q, state_d;

  logic [31:0]       lo_q, lo_d;
  logic [63:0]       data_q, data_d;
  logic [7:0]        keep_q, keep_d;
  logic              last_q, last_d;
  logic [USER_W-1:0] user_q, user_d;
  logic [USER_W-1:0] ureg_q, ureg_d;
  logic              valid_q, valid_d;
  logic              sop_q, sop_d;

  logic              ready;
  logic              s_xfr;
  logic              m_xfr;
  logic              load;
  logic [USER_W-1:0] cur_user;

  assign ready = ~valid_q | m_axis.tready;
  assign s_xfr = s_axis.tvalid & ready;
  assign m_xfr = valid_q & m_axis.tready;

  // A one-beat packet has no captured word yet, so take SRCDEST directly
  assign cur_user = sop_q ? s_axis.tuser : ureg_q;

  assign s_axis.tready = ready;
  assign m_axis.tdata  = data_q;
  assign m_axis.tkeep  = keep_q;
  assign m_axis.tlast  = last_q;
  assign m_axis.tuser  = user_q;
  assign m_axis.tvalid = valid_q;

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    user_d  = user_q;
    ureg_d  = ureg_q;
    sop_d   = sop_q;
    load    = 1'b0;

    unique case (state_q)
      LO_EMPTY: begin
        if (s_xfr) begin
          if (s_axis.tlast) begin
            load   = 1'b1;
            data_d = {PAD_WORD, s_axis.tdata};
            keep_d = 8'h0F;
            last_d = 1'b1;
          end else begin
            lo_d    = s_axis.tdata;
            state_d = LO_HELD;
          end
        end
      end
      LO_HELD: begin
        if (s_xfr) begin
          load    = 1'b1;
          data_d  = {s_axis.tdata, lo_q};
          keep_d  = 8'hFF;
          last_d  = s_axis.tlast;
          state_d = LO_EMPTY;
        end
      end
      default: state_d = LO_EMPTY;
    endcase

    if (load) begin
      user_d = cur_user;
    end

    if (s_xfr) begin
      sop_d = s_axis.tlast;
      if (sop_q) begin
        ureg_d = s_axis.tuser;
      end
    end
  end

  // A load in the same cycle as m_xfr replaces the old beat
  assign valid_d = load | (valid_q & ~m_xfr);

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q <= LO_EMPTY;
      lo_q    <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= '0;
      ureg_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      user_q  <= user_d;
      ureg_q  <= ureg_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
    end
  end

endmodule
